// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - RESET_PC_DEFAULT : default program counter after reset
//   - PC_INC           : byte increment between sequential fetches
//   - instruction field positions (opcode/rd/rs1/rs2/imm) for downstream users
//   - fetch_state_t    : fetch state machine encoding {RUN, FAULT}
//   - is_word_aligned  : helper for the redirect alignment check
// Optional feature macro used by the importing files: FETCH_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;

  // Instruction field positions (the fetch unit itself never decodes).
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_MSB     = 26;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS1_MSB    = 21;
  localparam int unsigned RS1_LSB    = 17;
  localparam int unsigned RS2_MSB    = 16;
  localparam int unsigned RS2_LSB    = 12;
  localparam int unsigned IMM_MSB    = 11;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [1:0] byte_offset);
    return (byte_offset == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Combinational next-PC selection and redirect alignment check.
// Selection priority: redirect target, then +PC_INC on advance, else hold.
// The reset value is applied by the PC register's asynchronous reset branch
// in fetch_unit, which takes precedence over everything selected here.
//
// Ports:
//   pc             in   DATA_WIDTH  current program counter
//   redirect_valid in   1           taken branch/jump this cycle
//   redirect_pc    in   DATA_WIDTH  redirect byte address
//   advance        in   1           fetch stage advances this cycle
//   next_pc        out  DATA_WIDTH  value the PC register loads on the edge
//   misaligned     out  1           redirect this cycle targets a non-word address
//
// Macro FETCH_ALIGN_CHECK_EN:
//   defined   -> target loaded as given, misaligned reported
//   undefined -> target's two low bits forced to zero, misaligned tied low
// -----------------------------------------------------------------------------
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(PC_INC);

  logic [DATA_WIDTH-1:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target     = redirect_pc;
  assign misaligned = redirect_valid && !is_word_aligned(redirect_pc[1:0]);
`else
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  assign target     = redirect_pc & ALIGN_MASK;
  assign misaligned = 1'b0;
`endif

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = target;
    end else if (advance) begin
      // Natural modulo-2^DATA_WIDTH wrap; the PC is not bounded by memory depth.
      next_pc = pc + INC;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the program counter, drives the word-aligned
// byte address into a combinational instruction memory and captures the
// returned instruction into an IF/ID register with a valid/ready handshake.
// Supports stall, redirect with flush, and an optional misaligned-target fault.
//
// Ports:
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous active-low reset
//   stall          in   1           hazard hold
//   redirect_valid in   1           taken branch/jump this cycle
//   redirect_pc    in   DATA_WIDTH  redirect byte address
//   imem_addr      out  DATA_WIDTH  byte address to instruction memory (= pc)
//   imem_instr     in   DATA_WIDTH  combinational instruction for imem_addr
//   id_valid       out  1           IF/ID register holds a valid instruction
//   id_ready       in   1           decode accepts id_* this cycle
//   id_instr       out  DATA_WIDTH  captured instruction
//   id_pc          out  DATA_WIDTH  address of id_instr
//   id_seq         out  8           count of captured instructions, mod 256
//   fetch_fault    out  1           sticky misaligned-redirect fault
//
// Macro FETCH_ALIGN_CHECK_EN enables the misaligned-redirect fault and the
// FAULT state; without it fetch_fault is tied low and FAULT is unreachable.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [7:0]            id_seq,
  output logic                  fetch_fault
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  fetch_state_t          state_reg, state_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic                  id_valid_reg;
  logic [DATA_WIDTH-1:0] id_instr_reg;
  logic [DATA_WIDTH-1:0] id_pc_reg;
  logic [7:0]            id_seq_reg;
  logic                  advance;
  logic                  misaligned;

  // Word index the instruction memory decodes from imem_addr. The PC itself
  // is never bounded by MEM_DEPTH, so addresses past the end alias silently.
  logic [IDX_W-1:0]      mem_index_unused;
  assign mem_index_unused = pc_reg[IDX_W+1:2];

  fetch_pc_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_gen (
    .pc             (pc_reg),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .next_pc        (pc_next),
    .misaligned     (misaligned)
  );

  // Next-state and advance decode.
  always_comb begin
    state_next = state_reg;
    advance    = 1'b0;
    case (state_reg)
      RUN: begin
        // A held IF/ID slot may be refilled only when decode takes it.
        advance = !stall && (!id_valid_reg || id_ready);
        if (misaligned) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // IF/ID register. Redirect flushes the slot even if decode is accepting it
  // this cycle; an accepted slot that cannot be refilled goes empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_reg <= 1'b0;
      id_instr_reg <= '0;
      id_pc_reg    <= '0;
      id_seq_reg   <= '0;
    end else if (redirect_valid) begin
      id_valid_reg <= 1'b0;
    end else if (advance) begin
      id_valid_reg <= 1'b1;
      id_instr_reg <= imem_instr;
      id_pc_reg    <= pc_reg;
      id_seq_reg   <= id_seq_reg + 8'd1;
    end else if (id_valid_reg && id_ready) begin
      id_valid_reg <= 1'b0;
    end
  end

  assign imem_addr = pc_reg;
  assign id_valid  = id_valid_reg;
  assign id_instr  = id_instr_reg;
  assign id_pc     = id_pc_reg;
  assign id_seq    = id_seq_reg;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = (state_reg == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized stall/ready/redirect traffic checked every
// cycle against a behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [7:0]  id_seq;
  logic        fetch_fault;

  logic [31:0] mem [256];

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  always #5 clk = ~clk;

  // Combinational instruction memory, 256 words, aliased by address.
  assign imem_instr = mem[imem_addr[9:2]];

  fetch_unit #(
    .DATA_WIDTH (32),
    .MEM_DEPTH  (256),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_seq         (id_seq),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the fetch stage as a PC plus one holding slot.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_instr, m_idpc;
  logic [7:0]  m_seq;
  logic        m_valid, m_fault;

  function automatic logic [31:0] model_target(input logic [31:0] t);
    logic [31:0] r;
    r = t;
    if (!ALIGN_CHK) r[1:0] = 2'b00;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'h0;
      m_valid <= 1'b0;
      m_instr <= 32'h0;
      m_idpc  <= 32'h0;
      m_seq   <= 8'h0;
      m_fault <= 1'b0;
    end else if (redirect_valid) begin
      m_pc    <= model_target(redirect_pc);
      m_valid <= 1'b0;
      if (ALIGN_CHK && (redirect_pc % 4 != 0)) m_fault <= 1'b1;
    end else if (!m_fault && !stall && (!m_valid || id_ready)) begin
      m_instr <= mem[(m_pc / 4) % 256];
      m_idpc  <= m_pc;
      m_valid <= 1'b1;
      m_pc    <= m_pc + 32'd4;
      m_seq   <= 8'((m_seq + 1) % 256);
    end else if (m_valid && id_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_addr",   imem_addr,   m_pc);
      chk("id_valid",    id_valid,    m_valid);
      chk("id_instr",    id_instr,    m_instr);
      chk("id_pc",       id_pc,       m_idpc);
      chk("id_seq",      id_seq,      m_seq);
      chk("fetch_fault", fetch_fault, m_fault);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] r, t;
    r = $urandom;
    if (r[3:0] == 4'h0) t = 32'hFFFF_FFF0 | (r & 32'hF);
    else                t = r & 32'h0000_07FF;
    if (ALIGN_CHK) t = t & 32'hFFFF_FFFC;
    return t;
  endfunction

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[5] = 32'h0000_0000;  // all-zero word must pass through untouched
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    #1 check_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_id_valid",  id_valid,    32'h0);
    chk("rst_imem_addr", imem_addr,   32'h0);
    chk("rst_id_seq",    id_seq,      32'h0);
    chk("rst_id_instr",  id_instr,    32'h0);
    chk("rst_fault",     fetch_fault, 32'h0);
    rst_n = 1'b1;

    // Sequential stream with a 3-cycle backpressure hold at id_pc=8
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      chk("seq_id_pc",    id_pc,    32'(4 * k));
      chk("seq_id_seq",   id_seq,   32'(k + 1));
      chk("seq_id_instr", id_instr, mem[k]);
      if (k == 2) begin
        id_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          next_cycle();
          chk("hold_id_pc",    id_pc,     32'h8);
          chk("hold_addr",     imem_addr, 32'hC);
          chk("hold_id_instr", id_instr,  mem[2]);
          chk("hold_id_valid", id_valid,  32'h1);
        end
        id_ready = 1'b1;
      end
    end

    // Redirect while a valid slot is being accepted
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    next_cycle();
    chk("redir_bubble", id_valid,  32'h0);
    chk("redir_addr",   imem_addr, 32'h40);
    redirect_valid = 1'b0;
    next_cycle();
    chk("redir_id_pc",    id_pc,    32'h40);
    chk("redir_id_instr", id_instr, mem[16]);

    // Redirect together with stall
    redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
    next_cycle();
    chk("rs_valid", id_valid,  32'h0);
    chk("rs_addr",  imem_addr, 32'h80);
    redirect_valid = 1'b0;
    next_cycle();
    chk("rs_hold_addr",  imem_addr, 32'h80);
    chk("rs_hold_valid", id_valid,  32'h0);
    stall = 1'b0;
    next_cycle();
    chk("rs_id_pc",    id_pc,    32'h80);
    chk("rs_id_instr", id_instr, mem[32]);

    // Address alias past the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'h3F8;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle();
    chk("wrap_pc_3f8", id_pc, 32'h3F8);
    next_cycle();
    chk("wrap_pc_3fc", id_pc, 32'h3FC);
    next_cycle();
    chk("wrap_pc_400",    id_pc,    32'h400);
    chk("wrap_instr_400", id_instr, mem[0]);

    // id_seq wraps 255 -> 0
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (id_seq == 8'd255) found = 1'b1;
      else next_cycle();
    end
    chk("seq255_reached", 32'(found), 32'h1);
    next_cycle();
    chk("seq_wrap_zero", id_seq,   32'h0);
    chk("seq_wrap_vld",  id_valid, 32'h1);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    next_cycle();
    redirect_valid = 1'b0;
    if (ALIGN_CHK) begin
      chk("mis_addr",  imem_addr,   32'h42);
      chk("mis_fault", fetch_fault, 32'h1);
      for (int h = 0; h < 4; h++) begin
        next_cycle();
        chk("mis_stuck_valid", id_valid,    32'h0);
        chk("mis_stuck_fault", fetch_fault, 32'h1);
      end
    end else begin
      chk("mis_addr",  imem_addr,   32'h40);
      chk("mis_fault", fetch_fault, 32'h0);
      next_cycle();
      chk("mis_id_pc", id_pc, 32'h40);
    end

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("async_fault", fetch_fault, 32'h0);
    chk("async_addr",  imem_addr,   32'h0);
    chk("async_valid", id_valid,    32'h0);
    chk("async_seq",   id_seq,      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk("restart_id_pc",    id_pc,    32'h0);
    chk("restart_id_instr", id_instr, mem[0]);

    // Randomized traffic, inputs driven just after the rising edge
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      stall          = ($urandom_range(0, 9) < 2);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = rand_target();
    end
    @(posedge clk);
    #1;
    stall = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
